// File: rtl/spi_xfer_engine_if.sv
// spi_xfer_engine_if: host-side data/flag bus plus the SPI pins of the transfer engine.
// The master modport is the engine's view and the slave modport is the host/bus-model view.
interface spi_xfer_engine_if #(
   parameter int unsigned DATA_W = 8
);
   logic [DATA_W-1:0] DATA_IN;
   logic              SENDER_WRITE;
   logic              RECEIVER_READ;
   logic [DATA_W-1:0] DATA_OUT;
   logic              SENDER_REG_FULL;
   logic              SENDER_REG_EMPTY;
   logic              RECEIVER_REG_FULL;
   logic              RECEIVER_REG_EMPTY;
   logic              RX_OVERRUN;
   logic              BUSY;
   logic              SCK;
   logic              MOSI;
   logic              SS_N;
   logic              MISO;

   modport master (
      input  DATA_IN, SENDER_WRITE, RECEIVER_READ, MISO,
      output DATA_OUT, SENDER_REG_FULL, SENDER_REG_EMPTY, RECEIVER_REG_FULL,
             RECEIVER_REG_EMPTY, RX_OVERRUN, BUSY, SCK, MOSI, SS_N
   );

   modport slave (
      output DATA_IN, SENDER_WRITE, RECEIVER_READ, MISO,
      input  DATA_OUT, SENDER_REG_FULL, SENDER_REG_EMPTY, RECEIVER_REG_FULL,
             RECEIVER_REG_EMPTY, RX_OVERRUN, BUSY, SCK, MOSI, SS_N
   );
endinterface

// File: rtl/spi_xfer_engine.sv
// spi_xfer_engine: SPI master (CPHA=0) with 1-deep sender holding reg, shift reg and
// 1-deep receiver holding reg. Define SPI_LSB_FIRST_EN to shift LSB first (default MSB first).
module spi_xfer_engine #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned CLK_DIV = 2,
   parameter bit          CPOL    = 1'b0
) (
   input logic               S_CLK,
   input logic               CLR_N,
   spi_xfer_engine_if.master bus
);
   localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned TglW = $clog2(2 * DATA_W);
   localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
   localparam logic [TglW-1:0] TglLast = TglW'(2 * DATA_W - 1);

   typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] hold_q, shreg_q, data_out_q;
   logic              tx_full_q, rx_full_q, ovr_q;
   logic              sck_q, mosi_q, ss_n_q;
   logic [DivW-1:0]   div_q;
   logic [TglW-1:0]   tgl_q;
   logic              start_xfer, tick, last_tgl, done_go;
   logic              first_bit, next_bit;
   logic [DATA_W-1:0] shifted;

`ifdef SPI_LSB_FIRST_EN
   assign first_bit = hold_q[0];
   assign next_bit  = shreg_q[0];
   assign shifted   = {bus.MISO, shreg_q[DATA_W-1:1]};
`else
   assign first_bit = hold_q[DATA_W-1];
   assign next_bit  = shreg_q[DATA_W-1];
   assign shifted   = {shreg_q[DATA_W-2:0], bus.MISO};
`endif

   // FSM state register
   always_ff @(posedge S_CLK or negedge CLR_N) begin
      if (!CLR_N) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // Next-state logic; start_xfer covers both IDLE->LOAD and chained DONE->LOAD
   always_comb begin
      state_d    = state_q;
      start_xfer = 1'b0;
      done_go    = 1'b0;
      tick       = 1'b0;
      last_tgl   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (tx_full_q) begin
               start_xfer = 1'b1;
               state_d    = StLoad;
            end
         end
         StLoad: state_d = StShift;
         StShift: begin
            tick     = (div_q == DivLast);
            last_tgl = tick && (tgl_q == TglLast);
            if (last_tgl) state_d = StDone;
         end
         StDone: begin
            done_go = 1'b1;
            if (tx_full_q) begin
               start_xfer = 1'b1;
               state_d    = StLoad;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Sender holding reg: writes land only while empty; starting a transfer frees it
   always_ff @(posedge S_CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         hold_q    <= '0;
         tx_full_q <= 1'b0;
      end else if (start_xfer) begin
         tx_full_q <= 1'b0;
      end else if (bus.SENDER_WRITE && !tx_full_q) begin
         hold_q    <= bus.DATA_IN;
         tx_full_q <= 1'b1;
      end
   end

   // Shift reg, SCK divider and SPI pins; even toggle index = leading edge (sample)
   always_ff @(posedge S_CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         shreg_q <= '0;
         sck_q   <= CPOL;
         mosi_q  <= 1'b0;
         ss_n_q  <= 1'b1;
         div_q   <= '0;
         tgl_q   <= '0;
      end else if (start_xfer) begin
         shreg_q <= hold_q;
         mosi_q  <= first_bit;
         ss_n_q  <= 1'b0;
         sck_q   <= CPOL;
         div_q   <= '0;
         tgl_q   <= '0;
      end else if (state_q == StShift) begin
         if (tick) begin
            div_q <= '0;
            tgl_q <= tgl_q + 1'b1;
            sck_q <= ~sck_q;
            if (!tgl_q[0])            shreg_q <= shifted;
            else if (!last_tgl)       mosi_q  <= next_bit;
         end else begin
            div_q <= div_q + 1'b1;
         end
      end else if (done_go) begin
         ss_n_q <= 1'b1;
         mosi_q <= 1'b0;
      end
   end

   // Receiver holding reg; a read in the DONE cycle consumes the old word, so no overrun
   always_ff @(posedge S_CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         data_out_q <= '0;
         rx_full_q  <= 1'b0;
         ovr_q      <= 1'b0;
      end else if (done_go) begin
         data_out_q <= shreg_q;
         rx_full_q  <= 1'b1;
         if (rx_full_q && !bus.RECEIVER_READ)     ovr_q <= 1'b1;
         else if (rx_full_q && bus.RECEIVER_READ) ovr_q <= 1'b0;
      end else if (bus.RECEIVER_READ && rx_full_q) begin
         rx_full_q <= 1'b0;
         ovr_q     <= 1'b0;
      end
   end

   assign bus.DATA_OUT           = data_out_q;
   assign bus.SENDER_REG_FULL    = tx_full_q;
   assign bus.SENDER_REG_EMPTY   = ~tx_full_q;
   assign bus.RECEIVER_REG_FULL  = rx_full_q;
   assign bus.RECEIVER_REG_EMPTY = ~rx_full_q;
   assign bus.RX_OVERRUN         = ovr_q;
   assign bus.BUSY               = (state_q != StIdle);
   assign bus.SCK                = sck_q;
   assign bus.MOSI               = mosi_q;
   assign bus.SS_N               = ss_n_q;
endmodule

// File: tb/tb_spi_xfer_engine.sv
// tb_spi_xfer_engine: randomized self-checking bench with an SPI slave/monitor model.
module tb_spi_xfer_engine;
   localparam int unsigned W    = 8;
   localparam int unsigned DIV  = 2;
   localparam bit          CPOL = 1'b0;
   localparam int          PER  = 10;
   // Edges from the write-sampling edge to receiver-full: load, LOAD state, shift, DONE.
   localparam int          LAT  = 3 + 2 * W * DIV;

   logic S_CLK = 1'b0;
   logic CLR_N;

   spi_xfer_engine_if #(.DATA_W(W)) bus ();

   spi_xfer_engine #(.DATA_W(W), .CLK_DIV(DIV), .CPOL(CPOL)) dut (
      .S_CLK (S_CLK),
      .CLR_N (CLR_N),
      .bus   (bus)
   );

   always #(PER / 2) S_CLK = ~S_CLK;

   int checks = 0;
   int errors = 0;

   bit         loopback = 1'b1;
   logic [W-1:0] slave_byte = '0;
   logic       miso_drv;

   // Monitor state, written only by the monitor process
   int   slave_idx = 0;
   int   tgl_cnt   = 0;
   int   ss_falls  = 0;
   logic mosi_log[$];
   time  hi_w[$];
   time  rise_t    = 0;
   logic sck_prev  = 1'bx;
   logic ss_prev   = 1'bx;

   // Position i (0 = first on the wire) of byte b in the configured bit order
   function automatic logic exp_bit(input logic [W-1:0] b, input int i);
`ifdef SPI_LSB_FIRST_EN
      return b[i];
`else
      return b[W-1-i];
`endif
   endfunction

   assign miso_drv = exp_bit(slave_byte, slave_idx);
   assign bus.MISO = loopback ? bus.MOSI : miso_drv;

   // Slave model + bus monitor: record MOSI at leading edges, shift MISO at trailing edges
   always @(bus.SCK or bus.SS_N) begin
      if (bus.SS_N !== ss_prev) begin
         if (bus.SS_N === 1'b0) begin
            slave_idx = 0;
            ss_falls++;
         end
         ss_prev = bus.SS_N;
      end
      if (bus.SCK !== sck_prev) begin
         if (sck_prev !== 1'bx && bus.SCK !== 1'bx) begin
            tgl_cnt++;
            if (bus.SCK !== CPOL) begin
               mosi_log.push_back(bus.MOSI);
               rise_t = $time;
            end else begin
               hi_w.push_back($time - rise_t);
               slave_idx = (slave_idx == W - 1) ? 0 : slave_idx + 1;
            end
         end
         sck_prev = bus.SCK;
      end
   end

   task automatic step();
      @(posedge S_CLK);
      #1;
   endtask

   task automatic write_byte(input logic [W-1:0] d);
      bus.DATA_IN      = d;
      bus.SENDER_WRITE = 1'b1;
      step();
      bus.SENDER_WRITE = 1'b0;
   endtask

   task automatic read_rx();
      bus.RECEIVER_READ = 1'b1;
      step();
      bus.RECEIVER_READ = 1'b0;
   endtask

   task automatic test_reset();
      logic [8:0] got, want;
      string      nm[9];
      nm = '{"tx_empty", "tx_full", "rx_empty", "rx_full", "overrun", "busy", "sck", "mosi",
             "ss_n"};
      bus.SENDER_WRITE  = 1'b0;
      bus.RECEIVER_READ = 1'b0;
      bus.DATA_IN       = '0;
      CLR_N = 1'b1;
      #3;
      CLR_N = 1'b0;
      #1;
      got  = {bus.SENDER_REG_EMPTY, bus.SENDER_REG_FULL, bus.RECEIVER_REG_EMPTY,
              bus.RECEIVER_REG_FULL, bus.RX_OVERRUN, bus.BUSY, bus.SCK, bus.MOSI, bus.SS_N};
      want = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, CPOL, 1'b0, 1'b1};
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (got[8-i] !== want[8-i]) begin
            errors++;
            $display("FAIL reset_%s: got %b want %b", nm[i], got[8-i], want[8-i]);
         end
      end
      checks++;
      if (bus.DATA_OUT !== '0) begin
         errors++;
         $display("FAIL reset_data_out: got %0h want 0", bus.DATA_OUT);
      end
      step();
      step();
      CLR_N = 1'b1;
      step();
   endtask

   task automatic test_loopback(input logic [W-1:0] d);
      int           base, n;
      logic [W-1:0] gv, ev;
      loopback = 1'b1;
      base = mosi_log.size();
      write_byte(d);
      step();
      checks++;
      if (bus.SS_N !== 1'b0 || bus.BUSY !== 1'b1 || bus.SENDER_REG_EMPTY !== 1'b1) begin
         errors++;
         $display("FAIL load_state: got ss_n=%b busy=%b tx_empty=%b want 0 1 1",
                  bus.SS_N, bus.BUSY, bus.SENDER_REG_EMPTY);
      end
      n = 1;
      while (bus.RECEIVER_REG_FULL !== 1'b1 && n < LAT + 20) begin
         step();
         n++;
      end
      checks++;
      if (n !== LAT) begin
         errors++;
         $display("FAIL rx_latency: got %0d edges want %0d", n, LAT);
      end
      checks++;
      if (bus.DATA_OUT !== d) begin
         errors++;
         $display("FAIL loop_data: got %0h want %0h", bus.DATA_OUT, d);
      end
      gv = '0;
      ev = '0;
      for (int i = 0; i < int'(W); i++) begin
         ev[W-1-i] = exp_bit(d, i);
         if (base + i < mosi_log.size()) gv[W-1-i] = mosi_log[base+i];
      end
      checks++;
      if (mosi_log.size() - base != int'(W) || gv !== ev) begin
         errors++;
         $display("FAIL loop_mosi_bits: got %0d bits %b want %0d bits %b",
                  mosi_log.size() - base, gv, W, ev);
      end
      checks++;
      if (bus.SS_N !== 1'b1 || bus.BUSY !== 1'b0 || bus.MOSI !== 1'b0) begin
         errors++;
         $display("FAIL end_idle: got ss_n=%b busy=%b mosi=%b want 1 0 0",
                  bus.SS_N, bus.BUSY, bus.MOSI);
      end
      read_rx();
      checks++;
      if (bus.RECEIVER_REG_EMPTY !== 1'b1) begin
         errors++;
         $display("FAIL loop_read: got rx_empty=%b want 1", bus.RECEIVER_REG_EMPTY);
      end
   endtask

   task automatic test_slave(input logic [W-1:0] tx, input logic [W-1:0] rx);
      int           base, hb, n;
      logic [W-1:0] gv, ev;
      bit           bad_w;
      loopback   = 1'b0;
      slave_byte = rx;
      base = mosi_log.size();
      hb   = hi_w.size();
      write_byte(tx);
      n = 0;
      while (bus.RECEIVER_REG_FULL !== 1'b1 && n < LAT + 20) begin
         step();
         n++;
      end
      checks++;
      if (bus.DATA_OUT !== rx || bus.RECEIVER_REG_FULL !== 1'b1) begin
         errors++;
         $display("FAIL slave_data: got %0h full=%b want %0h full=1", bus.DATA_OUT,
                  bus.RECEIVER_REG_FULL, rx);
      end
      gv = '0;
      ev = '0;
      for (int i = 0; i < int'(W); i++) begin
         ev[W-1-i] = exp_bit(tx, i);
         if (base + i < mosi_log.size()) gv[W-1-i] = mosi_log[base+i];
      end
      checks++;
      if (mosi_log.size() - base != int'(W) || gv !== ev) begin
         errors++;
         $display("FAIL slave_mosi: got %0d pulses bits %b want %0d pulses bits %b",
                  mosi_log.size() - base, gv, W, ev);
      end
      bad_w = (hi_w.size() - hb != int'(W));
      for (int i = hb; i < hi_w.size(); i++) if (hi_w[i] != time'(DIV * PER)) bad_w = 1'b1;
      checks++;
      if (bad_w) begin
         errors++;
         $display("FAIL sck_pulse_width: got %0d pulses first width %0t want %0d of %0d",
                  hi_w.size() - hb, (hi_w.size() > hb) ? hi_w[hb] : 0, W, DIV * PER);
      end
      read_rx();
      loopback = 1'b1;
   endtask

   task automatic test_random();
      for (int k = 0; k < 6; k++) begin
         test_slave(W'($urandom), W'($urandom));
         test_loopback(W'($urandom));
      end
   endtask

   task automatic test_back_to_back(input logic [W-1:0] a, input logic [W-1:0] b);
      int           base, n;
      bit           gap, seen;
      logic [W-1:0] first;
      loopback = 1'b1;
      base  = ss_falls;
      gap   = 1'b0;
      seen  = 1'b0;
      first = '0;
      write_byte(a);
      step();
      write_byte(b);
      n = 0;
      while (n < 2 * LAT + 20) begin
         step();
         n++;
         if (bus.BUSY !== 1'b1) break;
         if (bus.SS_N !== 1'b0) gap = 1'b1;
         if (!seen && bus.RECEIVER_REG_FULL === 1'b1) begin
            seen  = 1'b1;
            first = bus.DATA_OUT;
         end
      end
      checks++;
      if (bus.BUSY !== 1'b0 || gap || ss_falls - base != 1) begin
         errors++;
         $display("FAIL chain_ss: got busy=%b gap=%b ss_falls=%0d want 0 0 1", bus.BUSY, gap,
                  ss_falls - base);
      end
      checks++;
      if (first !== a || bus.DATA_OUT !== b) begin
         errors++;
         $display("FAIL chain_data: got %0h,%0h want %0h,%0h", first, bus.DATA_OUT, a, b);
      end
      checks++;
      if (bus.RX_OVERRUN !== 1'b1) begin
         errors++;
         $display("FAIL overrun_set: got %b want 1", bus.RX_OVERRUN);
      end
      read_rx();
      checks++;
      if (bus.RX_OVERRUN !== 1'b0 || bus.RECEIVER_REG_EMPTY !== 1'b1) begin
         errors++;
         $display("FAIL overrun_clear: got ovr=%b rx_empty=%b want 0 1", bus.RX_OVERRUN,
                  bus.RECEIVER_REG_EMPTY);
      end
   endtask

   task automatic test_drop(input logic [W-1:0] x, input logic [W-1:0] y);
      int base, n;
      loopback = 1'b1;
      base = ss_falls;
      bus.DATA_IN      = x;
      bus.SENDER_WRITE = 1'b1;
      step();
      bus.DATA_IN = y;
      step();
      bus.SENDER_WRITE = 1'b0;
      checks++;
      if (bus.SENDER_REG_EMPTY !== 1'b1 || bus.SENDER_REG_FULL !== 1'b0) begin
         errors++;
         $display("FAIL drop_flags: got tx_empty=%b tx_full=%b want 1 0",
                  bus.SENDER_REG_EMPTY, bus.SENDER_REG_FULL);
      end
      n = 0;
      while (n < 2 * LAT + 20) begin
         step();
         n++;
      end
      checks++;
      if (ss_falls - base != 1 || bus.BUSY !== 1'b0) begin
         errors++;
         $display("FAIL drop_one_xfer: got %0d transfers busy=%b want 1 0", ss_falls - base,
                  bus.BUSY);
      end
      checks++;
      if (bus.DATA_OUT !== x || bus.RX_OVERRUN !== 1'b0) begin
         errors++;
         $display("FAIL drop_data: got %0h ovr=%b want %0h ovr=0", bus.DATA_OUT,
                  bus.RX_OVERRUN, x);
      end
      read_rx();
   endtask

   task automatic test_reset_mid();
      int tb, n;
      loopback = 1'b1;
      tb = tgl_cnt;
      write_byte(W'($urandom));
      n = 0;
      while (tgl_cnt - tb < 5 && n < LAT + 20) begin
         step();
         n++;
      end
      checks++;
      if (tgl_cnt - tb != 5) begin
         errors++;
         $display("FAIL reach_toggle5: got %0d toggles want 5", tgl_cnt - tb);
      end
      CLR_N = 1'b0;
      #1;
      checks++;
      if (bus.SS_N !== 1'b1 || bus.SCK !== CPOL || bus.BUSY !== 1'b0 || bus.MOSI !== 1'b0) begin
         errors++;
         $display("FAIL abort_pins: got ss_n=%b sck=%b busy=%b mosi=%b want 1 %b 0 0",
                  bus.SS_N, bus.SCK, bus.BUSY, bus.MOSI, CPOL);
      end
      checks++;
      if (bus.SENDER_REG_EMPTY !== 1'b1 || bus.RECEIVER_REG_EMPTY !== 1'b1 ||
          bus.RX_OVERRUN !== 1'b0 || bus.DATA_OUT !== '0) begin
         errors++;
         $display("FAIL abort_flags: got tx_empty=%b rx_empty=%b ovr=%b data=%0h want 1 1 0 0",
                  bus.SENDER_REG_EMPTY, bus.RECEIVER_REG_EMPTY, bus.RX_OVERRUN, bus.DATA_OUT);
      end
      step();
      CLR_N = 1'b1;
      step();
      test_loopback(W'($urandom));
   endtask

   task automatic test_bit_order();
      int base;
      base = mosi_log.size();
      test_loopback(W'(1));
      checks++;
      if (mosi_log.size() <= base || mosi_log[base] !== exp_bit(W'(1), 0)) begin
         errors++;
         $display("FAIL first_bit: got %b want %b",
                  (mosi_log.size() > base) ? mosi_log[base] : 1'bx, exp_bit(W'(1), 0));
      end
   endtask

   initial begin
      test_reset();
      test_loopback(8'hA5);
      test_slave(8'hFF, 8'h3C);
      test_random();
      test_back_to_back(8'h11, 8'h22);
      test_drop(W'($urandom), W'($urandom));
      test_reset_mid();
      test_bit_order();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
